// File: rtl/p2s_pkg.sv
// p2s_pkg
// Shared defaults and state encoding for the 4-lane parallel-to-serial striper.
//   DATA_W   : bits per lane byte
//   LANES    : number of serial lanes
//   IDLE_SYM : byte sent on every lane when no word is transferred
//   state_e  : ST_IDLE (0) / ST_DATA (1)
package p2s_pkg;

   localparam int DATA_W = 8;
   localparam int LANES  = 4;
   localparam logic [DATA_W-1:0] IDLE_SYM = 8'hBC;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } state_e;

endpackage

// File: rtl/p2s_lane.sv
// p2s_lane
// One serial lane: a DATA_W-bit shift register that is loaded with a new byte,
// shifted left MSB-first with zero fill, or held. The MSB is the lane output.
// Ports:
//   CLK     : clock, rising edge
//   reset   : asynchronous active-low reset, loads IDLE_SYM
//   load_i  : load data_i on this edge (has priority over shift_i)
//   shift_i : shift left by one on this edge
//   data_i  : byte to load
//   msb_o   : current MSB, i.e. the bit on the wire
module p2s_lane #(
   parameter int DATA_W = p2s_pkg::DATA_W,
   parameter logic [DATA_W-1:0] IDLE_SYM = p2s_pkg::IDLE_SYM
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              msb_o
);

   import p2s_pkg::*;

   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_d;

   // Next value of the lane register: a fresh byte on a load edge, a one-bit
   // left shift on other enabled edges, otherwise hold.
   always_comb begin
      shift_d = shift_q;
      if (load_i) begin
         shift_d = data_i;
      end else if (shift_i) begin
         shift_d = {shift_q[DATA_W-2:0], 1'b0};
      end
   end

   // Reset parks the lane on the idle symbol so the wire shows an idle MSB.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         shift_q <= IDLE_SYM;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign msb_o = shift_q[DATA_W-1];

endmodule

// File: rtl/p2s_striper.sv
// p2s_striper
// Accepts one LANES*DATA_W word per byte period over valid/ready, stripes
// byte k onto lane k and serializes every lane MSB-first. When no word is
// offered at a byte boundary, every lane sends IDLE_SYM instead.
// Ports:
//   CLK     : clock, rising edge
//   reset   : asynchronous active-low reset
//   ENB     : enable; low freezes counter, lanes and state
//   data_in : word; lane k takes data_in[DATA_W*k +: DATA_W]
//   valid   : data_in is offered (sampled only on load edges)
//   ready   : word is accepted on this edge if valid is high
//   s_out   : serial lanes, MSB first
//   sync    : high while a byte MSB is on s_out
//   active  : high while the byte on s_out is data rather than idle
module p2s_striper #(
   parameter int DATA_W = p2s_pkg::DATA_W,
   parameter int LANES  = p2s_pkg::LANES,
   parameter logic [DATA_W-1:0] IDLE_SYM = p2s_pkg::IDLE_SYM
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic                    ENB,
   input  logic [LANES*DATA_W-1:0] data_in,
   input  logic                    valid,
   output logic                    ready,
   output logic [LANES-1:0]        s_out,
   output logic                    sync,
   output logic                    active
);

   import p2s_pkg::*;

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   state_e           state_q;
   logic             loadEdge;
   logic             shiftEn;
   logic [LANES-1:0] laneMsb;

   // The last bit of a byte is on the wire when the counter sits at its top;
   // the following enabled edge is the only point where a new byte enters.
   assign loadEdge = ENB && (cnt_q == CNT_MAX);
   assign shiftEn  = ENB && !loadEdge;

   // Bit counter: advances on enabled edges and wraps at the byte boundary.
   always_comb begin
      cnt_d = cnt_q;
      if (ENB) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Byte-type state machine: it only changes at a byte boundary, so the
   // state always describes the byte currently being serialized.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else if (loadEdge) begin
         if (valid) begin
            state_q <= ST_DATA;
         end else begin
            state_q <= ST_IDLE;
         end
      end
   end

   // One shift register per lane; each takes its own byte of the word, or
   // the idle symbol when nothing is offered at the boundary.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [DATA_W-1:0] laneLoad;

      assign laneLoad = valid ? data_in[DATA_W*k +: DATA_W] : IDLE_SYM;

      p2s_lane #(
         .DATA_W   (DATA_W),
         .IDLE_SYM (IDLE_SYM)
      ) u_lane (
         .CLK     (CLK),
         .reset   (reset),
         .load_i  (loadEdge),
         .shift_i (shiftEn),
         .data_i  (laneLoad),
         .msb_o   (laneMsb[k])
      );
   end

   assign ready  = loadEdge;
   assign s_out  = laneMsb;
   assign sync   = (cnt_q == '0);
   assign active = (state_q == ST_DATA);

endmodule

// File: tb/tb_p2s_striper.sv
// tb_p2s_striper
// Drives p2s_striper and compares every cycle against a byte-level model:
// the model remembers which byte each lane is sending and which bit position
// is on the wire, and reads the expected bit straight out of that byte.
module tb_p2s_striper;

   localparam int DATA_W = 8;
   localparam int LANES  = 4;
   localparam logic [7:0] IDLE = 8'hBC;

   logic        CLK;
   logic        reset;
   logic        ENB;
   logic [31:0] data_in;
   logic        valid;
   logic        ready;
   logic [3:0]  s_out;
   logic        sync;
   logic        active;

   int testCount;
   int failCount;

   // Reference model: current byte per lane, bit position, data/idle flag.
   int         mCnt;
   logic [7:0] mByte [LANES];
   bit         mActive;

   logic [31:0] laneBits [LANES];

   p2s_striper dut (
      .CLK     (CLK),
      .reset   (reset),
      .ENB     (ENB),
      .data_in (data_in),
      .valid   (valid),
      .ready   (ready),
      .s_out   (s_out),
      .sync    (sync),
      .active  (active)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic void modelReset();
      mCnt = 0;
      mActive = 1'b0;
      for (int k = 0; k < LANES; k++) mByte[k] = IDLE;
   endfunction

   function automatic logic [3:0] modelSout();
      logic [3:0] r;
      for (int k = 0; k < LANES; k++) r[k] = mByte[k][DATA_W-1-mCnt];
      return r;
   endfunction

   function automatic logic modelReady();
      return (mCnt == DATA_W - 1) && ENB;
   endfunction

   function automatic void clearBits();
      for (int k = 0; k < LANES; k++) laneBits[k] = '0;
   endfunction

   function automatic void collectBits();
      for (int k = 0; k < LANES; k++) laneBits[k] = {laneBits[k][30:0], s_out[k]};
   endfunction

   // Drive inputs just after the falling edge and let them settle.
   task automatic applyStimulus(input logic en, input logic v, input logic [31:0] d);
      ENB = en;
      valid = v;
      data_in = d;
      #1;
   endtask

   // Advance one clock; the model follows the rules at the rising edge.
   task automatic clockEdge();
      @(posedge CLK);
      if (!reset) begin
         modelReset();
      end else if (ENB) begin
         if (mCnt == DATA_W - 1) begin
            for (int k = 0; k < LANES; k++) mByte[k] = valid ? data_in[8*k +: 8] : IDLE;
            mActive = valid;
            mCnt = 0;
         end else begin
            mCnt++;
         end
      end
      @(negedge CLK);
   endtask

   // Idle along until the next edge is a load edge (bounded).
   task automatic waitLoad();
      int guard;
      guard = 0;
      while (mCnt != DATA_W - 1 && guard < 20) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         clockEdge();
         guard++;
      end
      testCount++;
      if (mCnt != DATA_W - 1) begin
         failCount++;
         $display("[TB] FAIL waitLoad timeout: cnt=%0d required=%0d", mCnt, DATA_W - 1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      modelReset();
      applyStimulus(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         #1;
         testCount++;
         if ({s_out, sync, active, ready} !== {4'hF, 1'b1, 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL reset_values: s_out/sync/active/ready=%h/%b/%b/%b required=f/1/0/0",
                     s_out, sync, active, ready);
         end
      end
      reset = 1'b1;
      clearBits();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         testCount++;
         if ({ready, sync, active, s_out} !== {modelReady(), mCnt == 0, mActive, modelSout()}) begin
            failCount++;
            $display("[TB] FAIL reset_idle cycle %0d: ready/sync/active/s_out=%b/%b/%b/%h required=%b/%b/%b/%h",
                     i, ready, sync, active, s_out, modelReady(), mCnt == 0, mActive, modelSout());
         end
         collectBits();
         clockEdge();
      end
      for (int k = 0; k < LANES; k++) begin
         testCount++;
         if (laneBits[k][15:0] !== {IDLE, IDLE}) begin
            failCount++;
            $display("[TB] FAIL reset_idle_pattern lane %0d: got %h required %h", k, laneBits[k][15:0], {IDLE, IDLE});
         end
      end
   endtask

   task automatic test_single_word();
      logic [7:0] expByte [LANES];
      int activeCount;
      expByte[3] = 8'hA5; expByte[2] = 8'h3C; expByte[1] = 8'hF0; expByte[0] = 8'h81;
      activeCount = 0;
      clearBits();
      waitLoad();
      for (int i = 0; i < 18; i++) begin
         applyStimulus(1'b1, i == 0, (i == 0) ? 32'hA53CF081 : 32'h0);
         testCount++;
         if ({ready, sync, active, s_out} !== {modelReady(), mCnt == 0, mActive, modelSout()}) begin
            failCount++;
            $display("[TB] FAIL single_word cycle %0d: ready/sync/active/s_out=%b/%b/%b/%h required=%b/%b/%b/%h",
                     i, ready, sync, active, s_out, modelReady(), mCnt == 0, mActive, modelSout());
         end
         if (i >= 1 && i <= 8) collectBits();
         if (i >= 1 && i <= 16 && active === 1'b1) activeCount++;
         clockEdge();
      end
      for (int k = 0; k < LANES; k++) begin
         testCount++;
         if (laneBits[k][7:0] !== expByte[k]) begin
            failCount++;
            $display("[TB] FAIL single_word_pattern lane %0d: got %h required %h", k, laneBits[k][7:0], expByte[k]);
         end
      end
      testCount++;
      if (activeCount != 8) begin
         failCount++;
         $display("[TB] FAIL single_word_active_len: got %0d required 8", activeCount);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [4];
      int activeCount;
      int readyCount;
      words[0] = 32'h11223344; words[1] = 32'h55667788;
      words[2] = 32'h99AABBCC; words[3] = 32'hDDEEFF00;
      activeCount = 0;
      readyCount = 0;
      clearBits();
      waitLoad();
      for (int i = 0; i < 42; i++) begin
         applyStimulus(1'b1, i <= 24, (i < 32) ? words[i/8] : 32'h0);
         testCount++;
         if ({ready, sync, active, s_out} !== {modelReady(), mCnt == 0, mActive, modelSout()}) begin
            failCount++;
            $display("[TB] FAIL back_to_back cycle %0d: ready/sync/active/s_out=%b/%b/%b/%h required=%b/%b/%b/%h",
                     i, ready, sync, active, s_out, modelReady(), mCnt == 0, mActive, modelSout());
         end
         if (i < 32 && ready === 1'b1) readyCount++;
         if (i >= 1 && i <= 32) begin
            collectBits();
            if (active === 1'b1) activeCount++;
         end
         clockEdge();
      end
      for (int k = 0; k < LANES; k++) begin
         testCount++;
         if (laneBits[k] !== {words[0][8*k +: 8], words[1][8*k +: 8], words[2][8*k +: 8], words[3][8*k +: 8]}) begin
            failCount++;
            $display("[TB] FAIL back_to_back_stream lane %0d: got %h required %h", k, laneBits[k],
                     {words[0][8*k +: 8], words[1][8*k +: 8], words[2][8*k +: 8], words[3][8*k +: 8]});
         end
      end
      testCount++;
      if (activeCount != 32 || readyCount != 4) begin
         failCount++;
         $display("[TB] FAIL back_to_back_counts: active=%0d ready=%0d required 32/4", activeCount, readyCount);
      end
   endtask

   task automatic test_gap();
      logic [31:0] wordA;
      logic [31:0] wordB;
      int idleCount;
      wordA = $urandom;
      wordB = $urandom;
      idleCount = 0;
      clearBits();
      waitLoad();
      for (int i = 0; i < 34; i++) begin
         applyStimulus(1'b1, i == 0 || i == 16, (i == 0) ? wordA : ((i == 16) ? wordB : 32'h0));
         testCount++;
         if ({ready, sync, active, s_out} !== {modelReady(), mCnt == 0, mActive, modelSout()}) begin
            failCount++;
            $display("[TB] FAIL gap cycle %0d: ready/sync/active/s_out=%b/%b/%b/%h required=%b/%b/%b/%h",
                     i, ready, sync, active, s_out, modelReady(), mCnt == 0, mActive, modelSout());
         end
         if (i >= 1 && i <= 24) begin
            collectBits();
            if (active === 1'b0) idleCount++;
         end
         clockEdge();
      end
      for (int k = 0; k < LANES; k++) begin
         testCount++;
         if (laneBits[k][23:0] !== {wordA[8*k +: 8], IDLE, wordB[8*k +: 8]}) begin
            failCount++;
            $display("[TB] FAIL gap_stream lane %0d: got %h required %h", k, laneBits[k][23:0],
                     {wordA[8*k +: 8], IDLE, wordB[8*k +: 8]});
         end
      end
      testCount++;
      if (idleCount != 8) begin
         failCount++;
         $display("[TB] FAIL gap_idle_len: got %0d required 8", idleCount);
      end
   endtask

   task automatic test_enb_stall();
      logic [3:0] held;
      int activeCount;
      held = '0;
      activeCount = 0;
      clearBits();
      waitLoad();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(!(i >= 4 && i <= 8), i == 0, (i == 0) ? 32'hF0F0F0F0 : 32'h0);
         testCount++;
         if ({ready, sync, active, s_out} !== {modelReady(), mCnt == 0, mActive, modelSout()}) begin
            failCount++;
            $display("[TB] FAIL enb_stall cycle %0d: ready/sync/active/s_out=%b/%b/%b/%h required=%b/%b/%b/%h",
                     i, ready, sync, active, s_out, modelReady(), mCnt == 0, mActive, modelSout());
         end
         if (i == 4) held = s_out;
         if (i >= 5 && i <= 9) begin
            testCount++;
            if (s_out !== held || (i <= 8 && ready !== 1'b0)) begin
               failCount++;
               $display("[TB] FAIL enb_stall_hold cycle %0d: s_out/ready=%h/%b required=%h/0", i, s_out, ready, held);
            end
         end
         if ((i >= 1 && i <= 4) || (i >= 10 && i <= 13)) collectBits();
         if (i >= 1 && i <= 14 && active === 1'b1) activeCount++;
         clockEdge();
      end
      for (int k = 0; k < LANES; k++) begin
         testCount++;
         if (laneBits[k][7:0] !== 8'hF0) begin
            failCount++;
            $display("[TB] FAIL enb_stall_byte lane %0d: got %h required f0", k, laneBits[k][7:0]);
         end
      end
      testCount++;
      if (activeCount != 13) begin
         failCount++;
         $display("[TB] FAIL enb_stall_len: got %0d required 13", activeCount);
      end
   endtask

   task automatic test_reset_mid_byte();
      int activeCount;
      activeCount = 0;
      waitLoad();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, i == 0, (i == 0) ? $urandom : 32'h0);
         testCount++;
         if ({ready, sync, active, s_out} !== {modelReady(), mCnt == 0, mActive, modelSout()}) begin
            failCount++;
            $display("[TB] FAIL reset_mid pre cycle %0d: ready/sync/active/s_out=%b/%b/%b/%h required=%b/%b/%b/%h",
                     i, ready, sync, active, s_out, modelReady(), mCnt == 0, mActive, modelSout());
         end
         if (i < 5) clockEdge();
      end
      #2;
      reset = 1'b0;
      modelReset();
      #1;
      testCount++;
      if ({s_out, sync, active, ready} !== {4'hF, 1'b1, 1'b0, 1'b0}) begin
         failCount++;
         $display("[TB] FAIL reset_mid_immediate: s_out/sync/active/ready=%h/%b/%b/%b required=f/1/0/0",
                  s_out, sync, active, ready);
      end
      clockEdge();
      clockEdge();
      reset = 1'b1;
      clearBits();
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         testCount++;
         if ({ready, sync, active, s_out} !== {modelReady(), mCnt == 0, mActive, modelSout()}) begin
            failCount++;
            $display("[TB] FAIL reset_mid post cycle %0d: ready/sync/active/s_out=%b/%b/%b/%h required=%b/%b/%b/%h",
                     i, ready, sync, active, s_out, modelReady(), mCnt == 0, mActive, modelSout());
         end
         if (i < 16) collectBits();
         if (active === 1'b1) activeCount++;
         clockEdge();
      end
      for (int k = 0; k < LANES; k++) begin
         testCount++;
         if (laneBits[k][15:0] !== {IDLE, IDLE} || activeCount != 0) begin
            failCount++;
            $display("[TB] FAIL reset_mid_idle lane %0d: got %h active=%0d required %h active=0",
                     k, laneBits[k][15:0], activeCount, {IDLE, IDLE});
         end
      end
   endtask

   task automatic test_random();
      logic en;
      logic v;
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 7) != 0);
         v = $urandom_range(0, 1);
         applyStimulus(en, v, $urandom);
         testCount++;
         if ({ready, sync, active, s_out} !== {modelReady(), mCnt == 0, mActive, modelSout()}) begin
            failCount++;
            $display("[TB] FAIL random cycle %0d: ready/sync/active/s_out=%b/%b/%b/%h required=%b/%b/%b/%h",
                     i, ready, sync, active, s_out, modelReady(), mCnt == 0, mActive, modelSout());
         end
         clockEdge();
      end
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      reset = 1'b0;
      ENB = 1'b1;
      valid = 1'b0;
      data_in = '0;
      modelReset();
      test_reset();
      test_single_word();
      test_back_to_back();
      test_gap();
      test_enb_stall();
      test_reset_mid_byte();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
